// File: rtl/conv3x3_stream.sv
// Streaming 3x3 convolution over a raster image, valid-window only (no padding).
// Double-banked coefficients: writes land in a shadow bank that is copied to the active bank while idle.
//
// state | meaning
// IDLE  | between frames; active coefficients follow the shadow bank
// RUN   | frame in progress; active coefficients frozen
module conv3x3_stream #(
   parameter int DATA_W = 9,
   parameter int COEF_W = 9,
   parameter int ACC_W  = 20,
   parameter int IMG_W  = 8,
   parameter int IMG_H  = 8
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     in_valid,
   input  logic signed [DATA_W-1:0] in_data,
   input  logic                     coef_we,
   input  logic [3:0]               coef_addr,
   input  logic signed [COEF_W-1:0] coef_data,
   output logic                     out_valid,
   output logic signed [ACC_W-1:0]  out_data,
   output logic                     frame_done
);

   localparam int FULL_W = DATA_W + COEF_W + 4;
   localparam int PROD_W = DATA_W + COEF_W;
   localparam int CW     = $clog2(IMG_W);
   localparam int RW     = $clog2(IMG_H);
   localparam logic signed [FULL_W-1:0] ACC_MAX = FULL_W'((64'sd1 <<< (ACC_W - 1)) - 64'sd1);
   localparam logic signed [FULL_W-1:0] ACC_MIN = FULL_W'(-(64'sd1 <<< (ACC_W - 1)));
   localparam logic signed [COEF_W-1:0] COEF_ONE = COEF_W'(1);

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   state_t state, state_nxt;

   logic [CW-1:0] col;
   logic [RW-1:0] row;
   logic          last_px;
   logic          win_ok;

   logic signed [COEF_W-1:0] coef_shd [9];
   logic signed [COEF_W-1:0] coef_act [9];
   logic signed [DATA_W-1:0] lb1 [IMG_W];
   logic signed [DATA_W-1:0] lb2 [IMG_W];
   logic signed [DATA_W-1:0] win [9];
   logic signed [PROD_W-1:0] prod [9];

   logic v1, v2, d1, d2;
   logic signed [FULL_W-1:0] sum;
   logic signed [ACC_W-1:0]  sat;

   assign last_px = (row == RW'(IMG_H - 1)) && (col == CW'(IMG_W - 1));
   assign win_ok  = (row >= RW'(2)) && (col >= CW'(2));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         col <= '0;
         row <= '0;
      end else if (in_valid) begin
         if (col == CW'(IMG_W - 1)) begin
            col <= '0;
            row <= (row == RW'(IMG_H - 1)) ? '0 : row + RW'(1);
         end else begin
            col <= col + CW'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (in_valid) state_nxt = RUN;
         RUN:     if (in_valid && last_px) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // The active copy is taken on the same edge that accepts a frame's first pixel,
   // so a write in that cycle only reaches the shadow bank.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < 9; i++) begin
            coef_shd[i] <= (i == 4) ? COEF_ONE : '0;
            coef_act[i] <= (i == 4) ? COEF_ONE : '0;
         end
      end else begin
         if (coef_we && (coef_addr < 4'd9)) coef_shd[coef_addr] <= coef_data;
         if (state == IDLE) coef_act <= coef_shd;
      end
   end

   // Line buffers hold rows r-1 (lb1) and r-2 (lb2) at the current column.
   always_ff @(posedge clk) begin
      if (in_valid) begin
         win[0]   <= win[1];
         win[1]   <= win[2];
         win[2]   <= lb2[col];
         win[3]   <= win[4];
         win[4]   <= win[5];
         win[5]   <= lb1[col];
         win[6]   <= win[7];
         win[7]   <= win[8];
         win[8]   <= in_data;
         lb2[col] <= lb1[col];
         lb1[col] <= in_data;
      end
   end

   always_ff @(posedge clk) begin
      if (v1) begin
         for (int i = 0; i < 9; i++) prod[i] <= win[i] * coef_act[i];
      end
   end

   always_comb begin
      sum = '0;
      for (int i = 0; i < 9; i++) sum = sum + FULL_W'(prod[i]);
      sat = sum[ACC_W-1:0];
      if (sum > ACC_MAX)      sat = ACC_MAX[ACC_W-1:0];
      else if (sum < ACC_MIN) sat = ACC_MIN[ACC_W-1:0];
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         v1         <= 1'b0;
         d1         <= 1'b0;
         v2         <= 1'b0;
         d2         <= 1'b0;
         out_valid  <= 1'b0;
         frame_done <= 1'b0;
         out_data   <= '0;
      end else begin
         v1         <= in_valid && win_ok;
         d1         <= in_valid && last_px;
         v2         <= v1;
         d2         <= d1;
         out_valid  <= v2;
         frame_done <= d2;
         if (v2) out_data <= sat;
      end
   end

endmodule

// File: tb/tb_conv3x3_stream.sv
// Bench for conv3x3_stream on a 4x4 image: a frame-level reference model fills a
// scoreboard queue at stimulus time; a negedge monitor pops and compares each result.
module tb_conv3x3_stream;
   localparam int DW   = 9;
   localparam int CWD  = 9;
   localparam int AW   = 20;
   localparam int IW   = 4;
   localparam int IH   = 4;
   localparam int NPIX = IW * IH;
   localparam longint SAT_MAX = (64'sd1 <<< (AW - 1)) - 1;
   localparam longint SAT_MIN = -(64'sd1 <<< (AW - 1));

   logic                  clk = 1'b0;
   logic                  reset;
   logic                  in_valid;
   logic signed [DW-1:0]  in_data;
   logic                  coef_we;
   logic [3:0]            coef_addr;
   logic signed [CWD-1:0] coef_data;
   logic                  out_valid;
   logic signed [AW-1:0]  out_data;
   logic                  frame_done;

   conv3x3_stream #(
      .DATA_W(DW), .COEF_W(CWD), .ACC_W(AW), .IMG_W(IW), .IMG_H(IH)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .in_valid   (in_valid),
      .in_data    (in_data),
      .coef_we    (coef_we),
      .coef_addr  (coef_addr),
      .coef_data  (coef_data),
      .out_valid  (out_valid),
      .out_data   (out_data),
      .frame_done (frame_done)
   );

   always #5 clk = ~clk;

   typedef struct {
      longint val;
      bit     done;
      int     cyc;
   } exp_t;

   exp_t   exp_q[$];
   exp_t   mon_e;
   int     n_vec = 0;
   int     n_err = 0;
   int     cyc = 0;
   longint shadow_m [9];
   longint fcoef [9];
   longint fpix [NPIX];
   int     pidx = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input longint act, input longint req);
      n_vec++;
      if (act != req) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
      end
   endtask

   function automatic longint ref_out(input int r, input int c);
      longint s = 0;
      for (int i = 0; i < 9; i++)
         s += fcoef[i] * fpix[(r - 2 + i / 3) * IW + (c - 2 + i % 3)];
      if (s > SAT_MAX) s = SAT_MAX;
      if (s < SAT_MIN) s = SAT_MIN;
      return s;
   endfunction

   task automatic set_identity();
      for (int i = 0; i < 9; i++) shadow_m[i] = (i == 4) ? 1 : 0;
   endtask

   // One clock: drive inputs just after a rising edge; they are taken at the next one.
   task automatic step(input bit v, input longint d, input bit we, input int a, input longint cd);
      exp_t e;
      int   r, c;
      in_valid  = v;
      in_data   = DW'(d);
      coef_we   = we;
      coef_addr = 4'(a);
      coef_data = CWD'(cd);
      if (v) begin
         if (pidx == 0) fcoef = shadow_m;
         fpix[pidx] = d;
         r = pidx / IW;
         c = pidx % IW;
         if (r >= 2 && c >= 2) begin
            e.val  = ref_out(r, c);
            e.done = (pidx == NPIX - 1);
            e.cyc  = cyc + 3;
            exp_q.push_back(e);
         end
         pidx = (pidx + 1) % NPIX;
      end
      if (we && a < 9) shadow_m[a] = cd;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      coef_we  = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0);
   endtask

   task automatic load_all(input longint cd);
      for (int a = 0; a < 9; a++) step(0, 0, 1, a, cd);
      idle(2);
   endtask

   task automatic frame_const(input longint d);
      for (int i = 0; i < NPIX; i++) step(1, d, 0, 0, 0);
      idle(4);
   endtask

   task automatic frame_ramp();
      for (int i = 0; i < NPIX; i++) step(1, i, 0, 0, 0);
      idle(4);
   endtask

   always @(negedge clk) begin
      if (out_valid) begin
         if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_output: out_valid=1 out_data=%0d, required no pending result", out_data);
         end else begin
            mon_e = exp_q.pop_front();
            check("out_data", longint'(out_data), mon_e.val);
            check("frame_done", longint'(frame_done), longint'(mon_e.done));
            check("latency_cycle", cyc, mon_e.cyc);
         end
      end else if (frame_done) begin
         check("frame_done_without_valid", longint'(frame_done), 0);
      end
   end

   initial begin
      longint cd;
      reset     = 1'b0;
      in_valid  = 1'b0;
      in_data   = '0;
      coef_we   = 1'b0;
      coef_addr = '0;
      coef_data = '0;
      set_identity();
      #12;
      check("reset_out_valid", longint'(out_valid), 0);
      check("reset_frame_done", longint'(frame_done), 0);
      check("reset_out_data", longint'(out_data), 0);
      @(posedge clk);
      #1 reset = 1'b1;
      idle(2);

      // identity, back-to-back ramp: 5,6,9,10
      frame_ramp();

      // same ramp with a bubble after every pixel
      for (int i = 0; i < NPIX; i++) begin
         step(1, i, 0, 0, 0);
         step(0, 0, 0, 0, 0);
      end
      idle(4);

      load_all(1);
      frame_const(255);
      load_all(255);
      frame_const(-256);
      load_all(-256);
      frame_const(-256);

      // back to identity; coef[4]=2 written mid-frame only affects the following frame
      for (int a = 0; a < 9; a++) step(0, 0, 1, a, (a == 4) ? 1 : 0);
      idle(2);
      for (int i = 0; i < NPIX; i++) step(1, i, (i == 7), 4, 2);
      frame_ramp();

      // out-of-range addresses must be ignored
      for (int a = 9; a < 16; a++) step(0, 0, 1, a, 100 + a);
      idle(2);
      // write coincident with first pixel reaches the shadow bank only
      for (int i = 0; i < NPIX; i++) step(1, i, (i == 0), 4, 3);
      frame_ramp();

      // abort a frame with reset while a result is on the output
      for (int i = 0; i <= 12; i++) step(1, i, 0, 0, 0);
      reset = 1'b0;
      #1;
      check("midreset_out_valid", longint'(out_valid), 0);
      check("midreset_frame_done", longint'(frame_done), 0);
      check("midreset_out_data", longint'(out_data), 0);
      exp_q.delete();
      pidx = 0;
      set_identity();
      @(posedge clk);
      #1 reset = 1'b1;
      idle(1);
      frame_ramp();

      // randomized frames, gaps and coefficient writes
      for (int f = 0; f < 8; f++) begin
         for (int i = 0; i < NPIX; i++) begin
            while ($urandom_range(0, 3) == 0) begin
               cd = longint'($urandom_range(0, 511)) - 256;
               step(0, 0, ($urandom_range(0, 2) == 0), $urandom_range(0, 15), cd);
            end
            cd = longint'($urandom_range(0, 511)) - 256;
            step(1, longint'($urandom_range(0, 511)) - 256,
                 ($urandom_range(0, 3) == 0), $urandom_range(0, 15), cd);
         end
         if (f % 2 == 1) begin
            for (int a = 0; a < 9; a++) begin
               cd = longint'($urandom_range(0, 511)) - 256;
               step(0, 0, 1, a, cd);
            end
         end
      end

      idle(8);
      check("pending_results", exp_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/conv3x3_stream.md
CONV3X3_STREAM -- requirements
Module: conv3x3_stream

Interface
REQ-001 Parameter DATA_W, default 9, signed pixel width.
REQ-002 Parameter COEF_W, default 9, signed coefficient width.
REQ-003 Parameter ACC_W, default 20, signed output width; SHALL be <= DATA_W+COEF_W+4.
REQ-004 Parameter IMG_W, default 8, image columns; SHALL be >= 3.
REQ-005 Parameter IMG_H, default 8, image rows; SHALL be >= 3.
REQ-006 clk  input  1  single clock; all state updates on rising edge.
REQ-007 reset  input  1  asynchronous, active-low reset.
REQ-008 in_valid  input  1  pixel accepted on any rising edge where high; no backpressure.
REQ-009 in_data  input  DATA_W  signed pixel, raster order, row-major.
REQ-010 coef_we  input  1  coefficient write strobe.
REQ-011 coef_addr  input  4  coefficient index 0..8; writes to 9..15 SHALL be ignored.
REQ-012 coef_data  input  COEF_W  signed coefficient value.
REQ-013 out_valid  output  1  out_data valid this cycle.
REQ-014 out_data  output  ACC_W  signed saturated convolution result.
REQ-015 frame_done  output  1  one-cycle pulse coincident with last out_valid of a frame.

Function
REQ-016 Two line buffers of IMG_W entries plus a 3x3 window register SHALL hold the last three rows; window updates only on accepted pixels.
REQ-017 Column counter 0..IMG_W-1 and row counter 0..IMG_H-1 SHALL advance per accepted pixel; column wraps to 0 and increments row; row wraps to 0 after the last pixel of the frame.
REQ-018 FSM states IDLE, RUN: IDLE->RUN on accepted pixel; RUN->IDLE on acceptance of pixel (IMG_H-1, IMG_W-1); otherwise hold.
REQ-019 A result SHALL be produced only when the accepted pixel has row>=2 and col>=2 (valid-window mode, no padding): (IMG_W-2)*(IMG_H-2) results per frame.
REQ-020 Result = sum over i=0..8 of coef[i]*w[i]; w[0] = pixel (r-2,c-2), w[i] = pixel (r-2+i/3, c-2+i%3), w[8] = current pixel.
REQ-021 Products and sum SHALL be computed at full width DATA_W+COEF_W+4, then saturated to ACC_W signed range.
REQ-022 Latency: out_valid SHALL assert exactly 2 cycles after the rising edge accepting the completing pixel; pipeline advances every cycle regardless of in_valid.
REQ-023 Gaps in in_valid SHALL not change results, only their timing.
REQ-024 coef_we SHALL write a shadow bank; active bank SHALL be loaded from shadow on every cycle the FSM is in IDLE.
REQ-025 A write in the same cycle as the first pixel of a frame SHALL reach shadow only and SHALL not affect that frame.
REQ-026 Writes during RUN SHALL not affect the frame in progress; they apply from the next frame.
REQ-027 frame_done SHALL pulse with the result for pixel (IMG_H-1, IMG_W-1); otherwise low.

Reset
REQ-028 Asserting reset (low) SHALL immediately clear out_valid, frame_done, out_data=0, counters=0, FSM=IDLE, pipeline valid bits=0.
REQ-029 Both coefficient banks SHALL reset to identity: coef[4]=1, all others 0.
REQ-030 Line buffer and window contents need no reset; no result SHALL depend on pre-reset data.
REQ-031 Reset mid-frame SHALL abort the frame; next accepted pixel is treated as (0,0).

Verification (bench overrides IMG_W=4, IMG_H=4)
REQ-032 Reset, identity coefs, stream 0..15 back-to-back -> out_data 5,6,9,10, out_valid 2 cycles after pixels 10,11,14,15 accepted, frame_done with 10.
REQ-033 All coefs=1, all pixels=255 -> four outputs of 2295.
REQ-034 All coefs=255, all pixels=-256 -> four outputs of -524288 (negative saturation); coefs=-256, pixels=-256 -> 524287.
REQ-035 REQ-032 stimulus with in_valid low every other cycle -> identical values, each 2 cycles after its completing pixel.
REQ-036 Write coef[4]=2 after pixel 6 of frame 1 -> frame 1 outputs 5,6,9,10; frame 2 (same pixels) outputs 10,12,18,20.
REQ-037 Reset asserted after pixel 12 -> out_valid low immediately; new frame 0..15 with identity yields 5,6,9,10.
